// File: rtl/uart_abd_tx.sv
// UART transmitter for the auto-baud link: 8N1/8N2 frames, LSB first, with an
// optional sync character sent ahead of the data byte.
module uart_abd_tx #(
  parameter int unsigned BIT_DIV   = 16,
  parameter int unsigned STOP_BITS = 1,
  parameter logic [7:0]  SYNC_CHAR = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] brg,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       send_sync,
  output logic       UxTX,
  output logic       tx_busy,
  output logic       UxTXIF
);

  localparam int unsigned CW    = 13;
  localparam int unsigned NSTOP = (STOP_BITS == 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    brg_q;
  logic [7:0]    data_q;
  logic [7:0]    shift_q;
  logic          sync_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic          tx_q;
  logic          busy_q;
  logic          txif_q;

  logic [CW-1:0] lim_m1;
  logic          bit_tick;

  always_comb begin
    lim_m1   = CW'(BIT_DIV) * (CW'(brg_q) + CW'(1)) - CW'(1);
    bit_tick = (state_q != IDLE) && (cnt_q == lim_m1);
    cnt_d    = cnt_q + CW'(1);
    if (state_q == IDLE || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      brg_q   <= '0;
      data_q  <= '0;
      shift_q <= '0;
      sync_q  <= 1'b0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      txif_q  <= 1'b0;
    end else begin
      txif_q <= 1'b0;
      cnt_q  <= cnt_d;
      case (state_q)
        IDLE: begin
          if (tx_start && !busy_q) begin
            brg_q   <= brg;
            data_q  <= tx_data;
            sync_q  <= send_sync;
            shift_q <= send_sync ? SYNC_CHAR : tx_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if ((NSTOP == 2) && !stop_q) begin
              stop_q <= 1'b1;
            end else if (sync_q) begin
              // Sync frame done: chain straight into the data frame's start bit.
              sync_q  <= 1'b0;
              shift_q <= data_q;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              txif_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign UxTX    = tx_q;
  assign tx_busy = busy_q;
  assign UxTXIF  = txif_q;

endmodule

// File: tb/tb_uart_abd_tx.sv
// Scoreboard bench for uart_abd_tx: frames are queued at acceptance and a line
// monitor compares every clock of each frame against an arithmetic model.
module tb_uart_abd_tx;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  brg;
    logic        sync;
    int unsigned nstop;
    bit          gap1;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] brg_r;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       send_sync;
  logic       UxTX;
  logic       tx_busy;
  logic       UxTXIF;

  logic [7:0] t2_data;
  logic       t2_start;
  logic       t2_tx;
  logic       t2_busy;
  logic       t2_if;

  exp_t        exp_q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned frames_pushed = 0;
  int unsigned frames_seen = 0;
  bit          mon_busy = 0;
  longint      cyc = 0;
  longint      last_if_c = 0;

  uart_abd_tx #(.BIT_DIV(16), .STOP_BITS(1), .SYNC_CHAR(8'h55)) dut (
    .clk(clk), .rst(rst), .brg(brg_r), .tx_data(tx_data), .tx_start(tx_start),
    .send_sync(send_sync), .UxTX(UxTX), .tx_busy(tx_busy), .UxTXIF(UxTXIF)
  );

  uart_abd_tx #(.BIT_DIV(16), .STOP_BITS(2), .SYNC_CHAR(8'h55)) dut2 (
    .clk(clk), .rst(rst), .brg(8'd0), .tx_data(t2_data), .tx_start(t2_start),
    .send_sync(1'b0), .UxTX(t2_tx), .tx_busy(t2_busy), .UxTXIF(t2_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  function automatic int unsigned frame_len(exp_t e);
    int unsigned p = 16 * (int'(e.brg) + 1);
    return p * (9 + e.nstop) * (e.sync ? 2 : 1);
  endfunction

  // Line level i clocks after the first start-bit edge.
  function automatic logic exp_level(exp_t e, int unsigned i);
    int unsigned p     = 16 * (int'(e.brg) + 1);
    int unsigned bpf   = 9 + e.nstop;
    int unsigned bit_n = i / p;
    int unsigned k     = bit_n % bpf;
    logic [7:0]  ch    = (e.sync && bit_n < bpf) ? 8'h55 : e.data;
    if (k == 0) return 1'b0;
    if (k <= 8) return ch[k-1];
    return 1'b1;
  endfunction

  initial begin : monitor
    logic        prev;
    exp_t        e;
    int unsigned len, bad_w, bad_b;
    bit          aborted;
    longint      start_c;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !UxTX) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_start: got start bit at cycle %0d, required none", cyc);
        end else begin
          mon_busy = 1;
          e        = exp_q.pop_front();
          len      = frame_len(e);
          bad_w    = 0;
          bad_b    = 0;
          aborted  = 0;
          start_c  = cyc;
          for (int unsigned i = 0; i < len; i++) begin
            if (i != 0) @(negedge clk);
            if (rst) begin
              aborted = 1;
              break;
            end
            if (UxTX !== exp_level(e, i)) bad_w++;
            if (tx_busy !== 1'b1 || UxTXIF !== 1'b0) bad_b++;
          end
          if (!aborted) begin
            @(negedge clk);
            if (rst) aborted = 1;
          end
          if (!aborted) begin
            check("wave_err_count", bad_w, 0);
            check("busy_err_count", bad_b, 0);
            check("txif_busy_line_at_end", {UxTXIF, tx_busy, UxTX}, 3'b101);
            if (e.gap1) check("b2b_gap", start_c - last_if_c, 1);
            last_if_c = cyc;
            frames_seen++;
          end
          mon_busy = 0;
        end
      end
      prev = rst ? 1'b1 : UxTX;
    end
  end

  task automatic wait_idle_line();
    int unsigned w = 0;
    while (tx_busy && w < 50000) begin
      @(negedge clk);
      w++;
    end
    if (tx_busy) begin
      n_total++;
      $display("FAIL busy_timeout: got busy after %0d cycles, required idle", w);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] b, input logic s);
    @(negedge clk);
    wait_idle_line();
    tx_data   = d;
    brg_r     = b;
    send_sync = s;
    tx_start  = 1'b1;
    exp_q.push_back('{data: d, brg: b, sync: s, nstop: 1, gap1: 0});
    frames_pushed++;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((exp_q.size() != 0 || mon_busy || tx_busy) && w < 60000);
    if (w >= 60000) begin
      n_total++;
      $display("FAIL wait_done: got still active after %0d cycles, required idle", w);
    end
  endtask

  initial begin : stim
    int last0, if_idx;
    bit found;
    rst = 1'b1; brg_r = '0; tx_data = '0; tx_start = 1'b0; send_sync = 1'b0;
    t2_data = '0; t2_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {UxTX, tx_busy, UxTXIF}, 3'b100);
    check("reset_outputs_s2", {t2_tx, t2_busy, t2_if}, 3'b100);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {UxTX, tx_busy, UxTXIF}, 3'b100);

    send(8'hA5, 8'd0, 1'b0);
    wait_done();
    send(8'h00, 8'd3, 1'b0);
    wait_done();
    send(8'h3C, 8'd0, 1'b1);
    wait_done();

    // Inputs must be ignored while a frame is in flight.
    send(8'h5A, 8'd0, 1'b0);
    repeat (40) @(negedge clk);
    brg_r = 8'd7; tx_data = 8'hFF; send_sync = 1'b1; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; send_sync = 1'b0;
    wait_done();
    repeat (300) @(negedge clk);

    // Back-to-back with tx_start held high.
    @(negedge clk);
    brg_r = 8'd0; send_sync = 1'b0; tx_data = 8'h01; tx_start = 1'b1;
    exp_q.push_back('{data: 8'h01, brg: 8'd0, sync: 1'b0, nstop: 1, gap1: 0});
    frames_pushed++;
    @(negedge clk);
    wait_idle_line();
    tx_data = 8'h80;
    exp_q.push_back('{data: 8'h80, brg: 8'd0, sync: 1'b0, nstop: 1, gap1: 1});
    frames_pushed++;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of the data bits.
    send(8'hC3, 8'd1, 1'b0);
    repeat (160) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_mid_frame", {UxTX, tx_busy, UxTXIF}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    frames_pushed--;
    repeat (20) @(negedge clk);
    check("idle_after_mid_reset", {UxTX, tx_busy}, 2'b10);
    send(8'hA5, 8'd0, 1'b0);
    wait_done();

    for (int k = 0; k < 12; k++) begin
      send(8'($urandom), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    wait_done();
    send(8'($urandom), 8'd255, 1'b0);
    wait_done();

    // Two stop bits, brg=0, data 0x01: last low bit is bit 7, then 32 high clocks.
    @(negedge clk);
    t2_data = 8'h01; t2_start = 1'b1;
    @(negedge clk);
    t2_start = 1'b0;
    check("s2_start_low", t2_tx, 0);
    last0 = 0; if_idx = 0; found = 0;
    for (int i = 1; i < 400 && !found; i++) begin
      @(negedge clk);
      if (t2_if) begin
        found  = 1;
        if_idx = i;
      end else if (!t2_tx) begin
        last0 = i;
      end
    end
    check("s2_frame_len", if_idx, 176);
    check("s2_stop_high", if_idx - last0 - 1, 32);

    repeat (50) @(negedge clk);
    check("frames_completed", frames_seen, frames_pushed);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
